// File: rtl/irq_controller.sv
// Eight-input prioritised interrupt controller with edge-detected pending bits,
// in-service nesting and a small 16-bit register window for mask, vector base and EOI.
module irq_controller #(
  parameter int NUM_IRQS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic [1:1]          data_m_addr,
  input  logic [15:0]         data_m_data_in,
  output logic [15:0]         data_m_data_out,
  input  logic [1:0]          data_m_bytesel,
  input  logic                data_m_wr_en,
  input  logic                data_m_access,
  output logic                data_m_ack,
  input  logic [NUM_IRQS-1:0] irq,
  output logic                intr,
  input  logic                inta,
  output logic [7:0]          irq_vector
);

  logic [NUM_IRQS-1:0] mask;
  logic [NUM_IRQS-1:0] pending;
  logic [NUM_IRQS-1:0] in_service;
  logic [NUM_IRQS-1:0] irq_q;
  logic [4:0]          vector_base;

  logic                access;
  logic                wr;
  logic                rd;
  logic [NUM_IRQS-1:0] rise;
  logic [2:0]          cand;
  logic                cand_found;
  logic                eligible;
  logic                take;
  logic [NUM_IRQS-1:0] cand_onehot;
  logic [NUM_IRQS-1:0] pending_nxt;
  logic [NUM_IRQS-1:0] in_service_nxt;
  logic [15:0]         rd_data;
  logic                unused_data_bits;

  assign access           = cs & data_m_access;
  assign wr               = access & data_m_wr_en;
  assign rd               = access & ~data_m_wr_en;
  assign rise             = irq & ~irq_q;
  assign unused_data_bits = ^data_m_data_in[10:8];

  // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    for (int i = NUM_IRQS - 1; i >= 0; i--) begin
      if (pending[i] && !mask[i]) begin
        cand       = 3'(i);
        cand_found = 1'b1;
      end
    end
  end

  // An in-service bit at or above the candidate's priority blocks it.
  always_comb begin
    eligible = cand_found;
    for (int i = 0; i < NUM_IRQS; i++) begin
      if (3'(i) <= cand && in_service[i]) begin
        eligible = 1'b0;
      end
    end
  end

  assign take        = inta & intr & eligible;
  assign cand_onehot = take ? (NUM_IRQS'(1) << cand) : '0;

  // Clears are applied first so a same-edge rising irq or inta grant wins.
  always_comb begin
    pending_nxt    = pending & ~cand_onehot;
    in_service_nxt = in_service;
    if (wr && data_m_addr[1]) begin
      if (data_m_bytesel[0]) pending_nxt    = pending_nxt & ~data_m_data_in[7:0];
      if (data_m_bytesel[1]) in_service_nxt = in_service & ~data_m_data_in[15:8];
    end
    pending_nxt    = pending_nxt | rise;
    in_service_nxt = in_service_nxt | cand_onehot;
  end

  assign rd_data = data_m_addr[1] ? {in_service, pending} : {vector_base, 3'b000, mask};

  always_ff @(posedge clk) begin
    if (reset) begin
      mask            <= '1;
      vector_base     <= '0;
      pending         <= '0;
      in_service      <= '0;
      irq_q           <= '0;
      intr            <= 1'b0;
      irq_vector      <= '0;
      data_m_ack      <= 1'b0;
      data_m_data_out <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      irq_q           <= irq;
      pending         <= pending_nxt;
      in_service      <= in_service_nxt;
      intr            <= eligible;
      data_m_ack      <= access;
      data_m_data_out <= rd ? rd_data : 16'h0000;
      if (wr && !data_m_addr[1]) begin
        if (data_m_bytesel[0]) mask        <= data_m_data_in[7:0];
        if (data_m_bytesel[1]) vector_base <= data_m_data_in[15:11];
      end
      if (inta) begin
        irq_vector <= take ? {vector_base, cand} : {vector_base, 3'd7};
      end
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: the driver pushes expectations from a
// behavioural model, a negedge monitor pops and compares them.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic [1:1]  addr = 1'b0;
  logic [15:0] wdata = 16'h0;
  logic [15:0] rdata;
  logic [1:0]  bs = 2'b00;
  logic        wr_en = 1'b0;
  logic        access = 1'b0;
  logic        ack;
  logic [7:0]  irq = 8'h00;
  logic        intr;
  logic        inta = 1'b0;
  logic [7:0]  vec;

  irq_controller dut (
    .clk             (clk),
    .reset           (reset),
    .cs              (cs),
    .data_m_addr     (addr),
    .data_m_data_in  (wdata),
    .data_m_data_out (rdata),
    .data_m_bytesel  (bs),
    .data_m_wr_en    (wr_en),
    .data_m_access   (access),
    .data_m_ack      (ack),
    .irq             (irq),
    .intr            (intr),
    .inta            (inta),
    .irq_vector      (vec)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       intr;
    logic       ack;
    logic [7:0] vec;
  } cyc_exp_t;

  cyc_exp_t    exp_cyc_q[$];
  logic [15:0] exp_rd_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  // Reference model state
  logic [7:0] m_mask, m_pend, m_isr, m_irq_q, m_vec;
  logic [4:0] m_base;
  logic       m_intr;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int model_cand();
    for (int i = 0; i < 8; i++) if (m_pend[i] && !m_mask[i]) return i;
    return -1;
  endfunction

  // Eligible when no in-service bit of index 0..c is set, i.e. isr is a multiple of 2^(c+1).
  function automatic bit model_eligible(input int c);
    if (c < 0) return 1'b0;
    return (int'(m_isr) % (1 << (c + 1))) == 0;
  endfunction

  task automatic step();
    int         c;
    bit         elig, take, acc, wr;
    logic [7:0] onehot, pend_n, isr_n;
    if (reset) begin
      m_mask = 8'hFF; m_base = 5'd0; m_pend = 8'h00; m_isr = 8'h00;
      m_irq_q = 8'h00; m_intr = 1'b0; m_vec = 8'h00;
      exp_cyc_q.push_back(cyc_exp_t'{1'b0, 1'b0, 8'h00});
    end else begin
      c    = model_cand();
      elig = model_eligible(c);
      acc  = cs && access;
      wr   = acc && wr_en;
      take = inta && m_intr && elig;
      if (acc) exp_rd_q.push_back(wr_en ? 16'h0000 :
                                  (addr[1] ? {m_isr, m_pend} : {m_base, 3'b000, m_mask}));
      if (inta) m_vec = take ? {m_base, 3'(c)} : {m_base, 3'd7};
      onehot = take ? 8'(1 << c) : 8'h00;
      pend_n = m_pend & ~onehot;
      isr_n  = m_isr;
      if (wr && addr[1]) begin
        if (bs[0]) pend_n = pend_n & ~wdata[7:0];
        if (bs[1]) isr_n  = isr_n & ~wdata[15:8];
      end
      pend_n = pend_n | (irq & ~m_irq_q);
      isr_n  = isr_n | onehot;
      if (wr && !addr[1]) begin
        if (bs[0]) m_mask = wdata[7:0];
        if (bs[1]) m_base = wdata[15:11];
      end
      m_pend  = pend_n;
      m_isr   = isr_n;
      m_irq_q = irq;
      m_intr  = elig;
      exp_cyc_q.push_back(cyc_exp_t'{elig, acc, m_vec});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic bus_wr(input bit a, input logic [15:0] d, input logic [1:0] b);
    cs = 1'b1; access = 1'b1; wr_en = 1'b1; addr[1] = a; wdata = d; bs = b;
    step();
    cs = 1'b0; access = 1'b0; wr_en = 1'b0; bs = 2'b00;
  endtask

  task automatic bus_rd(input bit a);
    cs = 1'b1; access = 1'b1; wr_en = 1'b0; addr[1] = a;
    step();
    cs = 1'b0; access = 1'b0;
  endtask

  task automatic do_inta();
    inta = 1'b1;
    step();
    inta = 1'b0;
  endtask

  task automatic pulse(input int n);
    irq[n] = 1'b1;
    step();
    irq[n] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  // Monitor: one expectation per clocked step; read data popped on expected acks.
  initial begin
    cyc_exp_t e;
    forever begin
      @(negedge clk);
      if (exp_cyc_q.size() > 0) begin
        e = exp_cyc_q.pop_front();
        check("intr", 16'(intr), 16'(e.intr));
        check("ack", 16'(ack), 16'(e.ack));
        check("irq_vector", 16'(vec), 16'(e.vec));
        if (e.ack && exp_rd_q.size() > 0) check("rdata", rdata, exp_rd_q.pop_front());
        else check("rdata_idle", rdata, 16'h0000);
      end
    end
  end

  initial begin
    int r;
    do_reset();
    check("rst_intr", 16'(intr), 16'h0);
    check("rst_vec", 16'(vec), 16'h0);

    // Single request, vector = base | index
    bus_wr(1'b0, 16'h4000, 2'b11);
    pulse(3);
    bus_rd(1'b1);
    check("s1_pending", rdata, 16'h0008);
    do_inta();
    check("s1_vec", 16'(vec), 16'h0043);
    bus_rd(1'b1);
    check("s1_isr", rdata, 16'h0800);

    // Simultaneous requests: priority, then EOI releases the lower one
    do_reset();
    bus_wr(1'b0, 16'h4000, 2'b11);
    irq = 8'b0010_0010;
    step();
    irq = 8'h00;
    step();
    do_inta();
    check("s2_vec1", 16'(vec), 16'h0041);
    idle(3);
    check("s2_blocked", 16'(intr), 16'h0);
    bus_wr(1'b1, 16'h0200, 2'b11);
    idle(1);
    check("s2_after_eoi", 16'(intr), 16'h1);
    do_inta();
    check("s2_vec2", 16'(vec), 16'h0045);

    // Nesting
    do_reset();
    bus_wr(1'b0, 16'h4000, 2'b11);
    pulse(4);
    step();
    do_inta();
    pulse(2);
    step();
    check("s3_nest_intr", 16'(intr), 16'h1);
    do_inta();
    check("s3_vec", 16'(vec), 16'h0042);
    bus_rd(1'b1);
    check("s3_isr", rdata, 16'h1400);
    pulse(6);
    idle(2);
    check("s3_low_waits", 16'(intr), 16'h0);

    // Masked pending survives and fires when unmasked
    do_reset();
    bus_wr(1'b0, 16'h4000, 2'b10);
    pulse(0);
    bus_rd(1'b1);
    check("s4_pending", rdata, 16'h0001);
    idle(2);
    check("s4_masked", 16'(intr), 16'h0);
    bus_wr(1'b0, 16'h00FE, 2'b01);
    idle(1);
    check("s4_unmasked", 16'(intr), 16'h1);

    // Spurious inta and byte-select read-back
    do_reset();
    bus_wr(1'b0, 16'h40FF, 2'b11);
    do_inta();
    check("s5_spurious", 16'(vec), 16'h0047);
    bus_wr(1'b0, 16'h1234, 2'b01);
    bus_rd(1'b0);
    check("s5_lowbyte", rdata, 16'h4034);
    bus_wr(1'b0, 16'hA8FF, 2'b10);
    bus_rd(1'b0);
    check("s5_highbyte", rdata, 16'hA834);

    // Reset mid-access and mid-inta, level irq held across deassertion
    do_reset();
    bus_wr(1'b0, 16'h4000, 2'b11);
    pulse(0);
    step();
    do_inta();
    pulse(3);
    irq = 8'h04;
    reset = 1'b1; cs = 1'b1; access = 1'b1; inta = 1'b1;
    step();
    reset = 1'b0; cs = 1'b0; access = 1'b0; inta = 1'b0;
    check("s6_intr", 16'(intr), 16'h0);
    check("s6_vec", 16'(vec), 16'h0);
    check("s6_ack", 16'(ack), 16'h0);
    bus_rd(1'b0);
    check("s6_mask", rdata, 16'h00FF);
    bus_rd(1'b1);
    check("s6_level_pend", rdata, 16'h0004);
    irq = 8'h00;

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 2) == 0) irq = irq ^ (8'($urandom) & 8'($urandom));
      r      = $urandom_range(0, 9);
      cs     = ($urandom_range(0, 7) != 0);
      access = (r < 6);
      wr_en  = (r < 4);
      addr[1] = (r == 2 || r == 3 || r == 5);
      bs     = 2'($urandom);
      wdata  = (r < 2) ? {16'($urandom) & 16'($urandom)} : (16'($urandom) & 16'($urandom) & 16'($urandom));
      inta   = ($urandom_range(0, 3) == 0);
      step();
    end
    cs = 1'b0; access = 1'b0; wr_en = 1'b0; inta = 1'b0; irq = 8'h00; bs = 2'b00;
    idle(2);
    @(negedge clk);
    #1;
    check("drain_cyc", 16'(exp_cyc_q.size()), 16'h0);
    check("drain_rd", 16'(exp_rd_q.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
